// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO registers.
// One shift-add / restoring-subtract step per cycle, signs fixed up at the end.
module muldiv_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             Clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned      CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CntW-1:0]  CntLast = CntW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] OneW    = WIDTH'(1);
   localparam logic [2*WIDTH-1:0] OneP  = (2*WIDTH)'(1);

   typedef enum logic [2:0] {StIdle, StSetup, StIter, StFix, StDone} state_e;

   state_e           state_q;
   logic [1:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] acc_hi_q;   // product upper half / partial remainder
   logic [WIDTH-1:0] acc_lo_q;   // multiplier / quotient
   logic [WIDTH-1:0] opnd_q;     // multiplicand / divisor
   logic [CntW-1:0]  cnt_q;
   logic             neg_res_q, neg_rem_q;

   logic               is_div, is_signed;
   logic [WIDTH-1:0]   a_abs, b_abs;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     rem_shift;
   logic [WIDTH-1:0]   rem_sub;
   logic               rem_ge;
   logic [2*WIDTH-1:0] prod, prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;

   always_comb begin
      is_div    = op_q[1];
      is_signed = ~op_q[0];
      a_abs     = (is_signed && a_q[WIDTH-1]) ? (~a_q + OneW) : a_q;
      b_abs     = (is_signed && b_q[WIDTH-1]) ? (~b_q + OneW) : b_q;
      mul_sum   = {1'b0, acc_hi_q} + {1'b0, (acc_lo_q[0] ? opnd_q : '0)};
      rem_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
      rem_ge    = rem_shift >= {1'b0, opnd_q};
      // Result of a successful subtract is below the divisor, so WIDTH bits suffice.
      rem_sub   = rem_shift[WIDTH-1:0] - opnd_q;
      prod      = {acc_hi_q, acc_lo_q};
      prod_fix  = neg_res_q ? (~prod + OneP) : prod;
      quot_fix  = neg_res_q ? (~acc_lo_q + OneW) : acc_lo_q;
      rem_fix   = neg_rem_q ? (~acc_hi_q + OneW) : acc_hi_q;
   end

   always_ff @(posedge Clk) begin
      if (reset) begin
         state_q     <= StIdle;
         op_q        <= '0;
         a_q         <= '0;
         b_q         <= '0;
         acc_hi_q    <= '0;
         acc_lo_q    <= '0;
         opnd_q      <= '0;
         cnt_q       <= '0;
         neg_res_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         // Status outputs are registered from the state, one cycle behind it.
         busy <= (state_q == StSetup) || (state_q == StIter) || (state_q == StFix);
         done <= (state_q == StDone);
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  op_q        <= op;
                  a_q         <= a_in;
                  b_q         <= b_in;
                  div_by_zero <= 1'b0;
                  state_q     <= StSetup;
               end
            end
            StSetup: begin
               neg_res_q <= is_signed & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
               neg_rem_q <= is_signed & a_q[WIDTH-1];
               cnt_q     <= CntLast;
               acc_hi_q  <= '0;
               if (is_div) begin
                  acc_lo_q <= a_abs;
                  opnd_q   <= b_abs;
                  if (b_q == '0) begin
                     div_by_zero <= 1'b1;
                     state_q     <= StFix;
                  end else begin
                     state_q <= StIter;
                  end
               end else begin
                  acc_lo_q <= b_abs;
                  opnd_q   <= a_abs;
                  state_q  <= StIter;
               end
            end
            StIter: begin
               if (is_div) begin
                  acc_hi_q <= rem_ge ? rem_sub : rem_shift[WIDTH-1:0];
                  acc_lo_q <= {acc_lo_q[WIDTH-2:0], rem_ge};
               end else begin
                  acc_hi_q <= mul_sum[WIDTH:1];
                  acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
               end
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == '0) state_q <= StFix;
            end
            StFix: begin
               if (is_div && div_by_zero) begin
                  hi <= a_q;
                  lo <= '1;
               end else if (is_div) begin
                  hi <= rem_fix;
                  lo <= quot_fix;
               end else begin
                  hi <= prod_fix[2*WIDTH-1:WIDTH];
                  lo <= prod_fix[WIDTH-1:0];
               end
               state_q <= StDone;
            end
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO/flag queued at issue,
// popped and compared when done pulses.
module tb_muldiv_sequencer;

   logic        Clk = 1'b0;
   logic        reset, start;
   logic [1:0]  op;
   logic [31:0] a_in, b_in;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } res_t;

   res_t scb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   muldiv_sequencer #(.WIDTH(32)) dut (
      .Clk         (Clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .a_in        (a_in),
      .b_in        (b_in),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   always #5 Clk = ~Clk;

   // Behavioural reference using native wide arithmetic.
   function automatic res_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      res_t r;
      longint sa, sb;
      logic [63:0] p, q, m;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r  = '0;
      case (o)
         2'b00: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
         2'b01: begin p = {32'b0, a} * {32'b0, b}; r.hi = p[63:32]; r.lo = p[31:0]; end
         default: begin
            if (b == 32'h0) begin
               r.hi = a; r.lo = 32'hFFFF_FFFF; r.dbz = 1'b1;
            end else if (o == 2'b10) begin
               q = sa / sb; m = sa % sb; r.lo = q[31:0]; r.hi = m[31:0];
            end else begin
               r.lo = a / b; r.hi = a % b;
            end
         end
      endcase
      return r;
   endfunction

   // Called just after a rising edge; start is sampled at the next edge (E0).
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1; op = o; a_in = a; b_in = b;
      @(posedge Clk); #1;
      start = 1'b0;
      scb.push_back(model(o, a, b));
   endtask

   task automatic take_expected(output res_t e);
      if (scb.size() == 0) e = 'x;
      else e = scb.pop_front();
   endtask

   // Counts edges after E0 until done is seen; cycles = -1 on timeout.
   task automatic wait_done(input int budget, output int cycles, output int busy_cnt,
                            output logic [31:0] ghi, output logic [31:0] glo,
                            output logic gdbz, output logic gbusy);
      cycles = -1; busy_cnt = 0; ghi = 'x; glo = 'x; gdbz = 'x; gbusy = 'x;
      for (int c = 1; c <= budget; c++) begin
         @(posedge Clk); #1;
         if (done) begin
            cycles = c; ghi = hi; glo = lo; gdbz = div_by_zero; gbusy = busy;
            break;
         end
         if (busy) busy_cnt++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; start = 1'b0; op = 2'b00; a_in = '0; b_in = '0;
      repeat (3) @(posedge Clk);
      #1 reset = 1'b0;
      n_tests++;
      if ({busy, done, div_by_zero, hi, lo} !== 67'h0) begin
         n_fail++;
         $display("FAIL reset_state: got busy=%b done=%b dbz=%b hi=%h lo=%h expected all zero",
                  busy, done, div_by_zero, hi, lo);
      end
   endtask

   task automatic test_multu_max;
      int cyc, bc; logic [31:0] ghi, glo; logic gd, gb; res_t e;
      issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(100, cyc, bc, ghi, glo, gd, gb);
      take_expected(e);
      n_tests++;
      if (cyc !== 35) begin n_fail++; $display("FAIL multu_latency: got %0d expected 35", cyc); end
      n_tests++;
      if (bc !== 34) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d expected 34", bc); end
      n_tests++;
      if (gb !== 1'b0) begin n_fail++; $display("FAIL multu_busy_at_done: got %b expected 0", gb); end
      n_tests++;
      if ({ghi, glo} !== {e.hi, e.lo} || {ghi, glo} !== 64'hFFFF_FFFE_0000_0001) begin
         n_fail++; $display("FAIL multu_result: got %h_%h expected %h_%h", ghi, glo, e.hi, e.lo);
      end
   endtask

   task automatic test_signed;
      int cyc, bc; logic [31:0] ghi, glo; logic gd, gb; res_t e;
      logic [1:0]  ops [3] = '{2'b00, 2'b10, 2'b10};
      logic [31:0] as  [3] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h8000_0000};
      logic [31:0] bs  [3] = '{32'd6, 32'd2, 32'hFFFF_FFFF};
      for (int i = 0; i < 3; i++) begin
         issue(ops[i], as[i], bs[i]);
         wait_done(100, cyc, bc, ghi, glo, gd, gb);
         take_expected(e);
         n_tests++;
         if ({ghi, glo, gd} !== {e.hi, e.lo, e.dbz}) begin
            n_fail++;
            $display("FAIL signed_%0d: got hi=%h lo=%h dbz=%b expected hi=%h lo=%h dbz=%b",
                     i, ghi, glo, gd, e.hi, e.lo, e.dbz);
         end
      end
   endtask

   task automatic test_div_by_zero;
      int cyc, bc; logic [31:0] ghi, glo; logic gd, gb; res_t e;
      issue(2'b11, 32'd100, 32'd0);
      wait_done(100, cyc, bc, ghi, glo, gd, gb);
      take_expected(e);
      n_tests++;
      if (cyc !== 3) begin n_fail++; $display("FAIL dbz_latency: got %0d expected 3", cyc); end
      n_tests++;
      if ({ghi, glo, gd} !== {e.hi, e.lo, e.dbz}) begin
         n_fail++; $display("FAIL dbz_result: got hi=%h lo=%h dbz=%b expected hi=%h lo=%h dbz=%b",
                             ghi, glo, gd, e.hi, e.lo, e.dbz);
      end
      repeat (3) @(posedge Clk);
      #1;
      n_tests++;
      if (div_by_zero !== 1'b1) begin
         n_fail++; $display("FAIL dbz_sticky: got %b expected 1", div_by_zero);
      end
      issue(2'b11, 32'd100, 32'd7);
      wait_done(100, cyc, bc, ghi, glo, gd, gb);
      take_expected(e);
      n_tests++;
      if ({ghi, glo, gd} !== {e.hi, e.lo, e.dbz} || glo !== 32'd14) begin
         n_fail++; $display("FAIL divu_after_dbz: got hi=%h lo=%h dbz=%b expected hi=%h lo=%h dbz=%b",
                             ghi, glo, gd, e.hi, e.lo, e.dbz);
      end
   endtask

   task automatic test_ignore_start;
      int n_done = 0, late_busy = 0;
      logic [31:0] ghi = 'x, glo = 'x;
      res_t e;
      issue(2'b00, 32'h1234_5678, 32'hFEDC_BA98);
      for (int c = 1; c <= 45; c++) begin
         @(posedge Clk); #1;
         if (done) begin n_done++; ghi = hi; glo = lo; end
         if (c > 35 && busy) late_busy++;
         // Pulses land on edges E5, E20 and E35 (the DONE state).
         start = (c == 4 || c == 19 || c == 34);
         op = 2'b01; a_in = 32'd3; b_in = 32'd5;
      end
      start = 1'b0;
      take_expected(e);
      n_tests++;
      if (n_done !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", n_done); end
      n_tests++;
      if (late_busy !== 0) begin
         n_fail++; $display("FAIL ignore_start_in_done: got %0d busy cycles expected 0", late_busy);
      end
      n_tests++;
      if ({ghi, glo} !== {e.hi, e.lo}) begin
         n_fail++; $display("FAIL ignore_result: got %h_%h expected %h_%h", ghi, glo, e.hi, e.lo);
      end
   endtask

   task automatic test_mid_reset;
      int cyc, bc; logic [31:0] ghi, glo; logic gd, gb; res_t e;
      issue(2'b11, 32'd1000, 32'd3);
      repeat (9) begin @(posedge Clk); #1; end
      reset = 1'b1;
      @(posedge Clk); #1;
      reset = 1'b0;
      take_expected(e);
      n_tests++;
      if ({busy, done, hi, lo} !== 66'h0) begin
         n_fail++; $display("FAIL mid_reset: got busy=%b done=%b hi=%h lo=%h expected zeros",
                             busy, done, hi, lo);
      end
      issue(2'b11, 32'd1000, 32'd3);
      wait_done(100, cyc, bc, ghi, glo, gd, gb);
      take_expected(e);
      n_tests++;
      if (cyc !== 35) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 35", cyc); end
      n_tests++;
      if ({ghi, glo} !== {e.hi, e.lo} || glo !== 32'd333) begin
         n_fail++; $display("FAIL post_reset_result: got hi=%h lo=%h expected hi=%h lo=%h",
                             ghi, glo, e.hi, e.lo);
      end
   endtask

   task automatic test_back_to_back;
      int cyc, bc; logic [31:0] ghi, glo; logic gd, gb; res_t e;
      issue(2'b01, 32'd123_456, 32'd789);
      a_in = 32'hDEAD_BEEF; b_in = 32'h0BAD_F00D;
      wait_done(100, cyc, bc, ghi, glo, gd, gb);
      take_expected(e);
      n_tests++;
      if ({ghi, glo} !== {e.hi, e.lo}) begin
         n_fail++; $display("FAIL b2b_first: got %h_%h expected %h_%h", ghi, glo, e.hi, e.lo);
      end
      @(posedge Clk); #1;
      issue(2'b10, 32'hFFFF_FC18, 32'd7);
      a_in = 32'h5555_5555; b_in = 32'd0;
      wait_done(100, cyc, bc, ghi, glo, gd, gb);
      take_expected(e);
      n_tests++;
      if (cyc !== 35) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 35", cyc); end
      n_tests++;
      if ({ghi, glo, gd} !== {e.hi, e.lo, e.dbz}) begin
         n_fail++; $display("FAIL b2b_second: got hi=%h lo=%h dbz=%b expected hi=%h lo=%h dbz=%b",
                             ghi, glo, gd, e.hi, e.lo, e.dbz);
      end
   endtask

   task automatic test_random;
      int cyc, bc; logic [31:0] ghi, glo; logic gd, gb; res_t e;
      logic [1:0] o; logic [31:0] a, b;
      for (int i = 0; i < 12; i++) begin
         o = 2'($urandom_range(0, 3));
         a = $urandom;
         b = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
         if (i % 4 == 1) b = -b;
         issue(o, a, b);
         wait_done(100, cyc, bc, ghi, glo, gd, gb);
         take_expected(e);
         n_tests++;
         if ({ghi, glo, gd} !== {e.hi, e.lo, e.dbz}) begin
            n_fail++;
            $display("FAIL random_%0d op=%0d a=%h b=%h: got hi=%h lo=%h dbz=%b expected hi=%h lo=%h dbz=%b",
                     i, o, a, b, ghi, glo, gd, e.hi, e.lo, e.dbz);
         end
      end
   endtask

   initial begin
      test_reset();
      test_multu_max();
      test_signed();
      test_div_by_zero();
      test_ignore_start();
      test_mid_reset();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
      $fatal(1);
   end

endmodule
